// File: rtl/rmt_ethertype_filter_if.sv
// AXI-Stream bundle shared by the EtherType filter sink and source sides.
// master drives tdata/tkeep/tvalid/tlast/tuser, slave drives tready.
interface rmt_ethertype_filter_if #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (
      output tdata, tkeep, tvalid, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tuser,
      output tready
   );
endinterface

// File: rtl/rmt_ethertype_filter.sv
// Per-frame EtherType pass/drop filter with a one-deep AXI-S output register.
// Ports: clk, rst_n (async, active-low); s_axis sink, m_axis source;
// cfg_ethertype/cfg_enable/cfg_mode match table; stat_* saturating counters.
module rmt_ethertype_filter #(
   parameter int DATA_WIDTH  = 512,
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int USER_WIDTH  = 1,
   parameter int MATCH_COUNT = 4,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   rmt_ethertype_filter_if.slave    s_axis,
   rmt_ethertype_filter_if.master   m_axis,
   input  logic [MATCH_COUNT*16-1:0] cfg_ethertype,
   input  logic [MATCH_COUNT-1:0]    cfg_enable,
   input  logic                      cfg_mode,
   output logic [COUNT_WIDTH-1:0]    stat_pass_count,
   output logic [COUNT_WIDTH-1:0]    stat_drop_count,
   output logic [COUNT_WIDTH-1:0]    stat_runt_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t r_state;

   logic [DATA_WIDTH-1:0] r_tdata;
   logic [KEEP_WIDTH-1:0] r_tkeep;
   logic [USER_WIDTH-1:0] r_tuser;
   logic                  r_tlast;
   logic                  r_tvalid;

   logic [COUNT_WIDTH-1:0] r_pass_cnt;
   logic [COUNT_WIDTH-1:0] r_drop_cnt;
   logic [COUNT_WIDTH-1:0] r_runt_cnt;

   logic [15:0] w_etype;
   logic        w_match;
   logic        w_runt;
   logic        w_pass_dec;
   logic        w_first;
   logic        w_drop_now;
   logic        w_out_ready;
   logic        w_tready;
   logic        w_acc;
   logic        w_fwd;

   // Frame byte 12 is the EtherType MSB.
   assign w_etype = {s_axis.tdata[96+:8], s_axis.tdata[104+:8]};

   always_comb begin
      w_match = 1'b0;
      for (int i = 0; i < MATCH_COUNT; i++) begin
         if (cfg_enable[i] && (cfg_ethertype[16*i+:16] == w_etype))
            w_match = 1'b1;
      end
   end

   assign w_runt      = (s_axis.tkeep[13:12] != 2'b11);
   assign w_pass_dec  = !w_runt && (w_match ^ cfg_mode);
   assign w_first     = (r_state == IDLE);

   // Dropped beats bypass the output register, so they never stall.
   assign w_drop_now  = (r_state == DROP) || (w_first && !w_pass_dec);
   assign w_out_ready = !r_tvalid || m_axis.tready;
   assign w_tready    = rst_n && (w_drop_now || w_out_ready);
   assign w_acc       = s_axis.tvalid && w_tready;
   assign w_fwd       = w_acc && !w_drop_now;

   assign s_axis.tready = w_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else if (w_acc) begin
         case (r_state)
            IDLE: begin
               if (!s_axis.tlast)
                  r_state <= w_pass_dec ? PASS : DROP;
            end
            PASS, DROP: begin
               if (s_axis.tlast)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tuser  <= '0;
         r_tlast  <= 1'b0;
      end else if (w_fwd) begin
         r_tvalid <= 1'b1;
         r_tdata  <= s_axis.tdata;
         r_tkeep  <= s_axis.tkeep;
         r_tuser  <= s_axis.tuser;
         r_tlast  <= s_axis.tlast;
      end else if (m_axis.tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tdata  = r_tdata;
   assign m_axis.tkeep  = r_tkeep;
   assign m_axis.tuser  = r_tuser;
   assign m_axis.tlast  = r_tlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pass_cnt <= '0;
         r_drop_cnt <= '0;
         r_runt_cnt <= '0;
      end else if (w_acc && w_first) begin
         if (w_pass_dec) begin
            if (r_pass_cnt != '1)
               r_pass_cnt <= r_pass_cnt + 1'b1;
         end else begin
            if (r_drop_cnt != '1)
               r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_runt && (r_runt_cnt != '1))
               r_runt_cnt <= r_runt_cnt + 1'b1;
         end
      end
   end

   assign stat_pass_count = r_pass_cnt;
   assign stat_drop_count = r_drop_cnt;
   assign stat_runt_count = r_runt_cnt;

endmodule

// File: tb/tb_rmt_ethertype_filter.sv
// Directed self-checking bench for rmt_ethertype_filter.
// Uses 128-bit data and 4-bit counters so saturation is reachable.
module tb_rmt_ethertype_filter;

   localparam int DW = 128;
   localparam int KW = 16;
   localparam int UW = 1;
   localparam int MC = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rmt_ethertype_filter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
   rmt_ethertype_filter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

   logic [MC*16-1:0] cfg_et;
   logic [MC-1:0]    cfg_en;
   logic             cfg_mode;
   logic [CW-1:0]    st_pass;
   logic [CW-1:0]    st_drop;
   logic [CW-1:0]    st_runt;

   rmt_ethertype_filter #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
      .MATCH_COUNT(MC), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_axis(s_if),
      .m_axis(m_if),
      .cfg_ethertype(cfg_et),
      .cfg_enable(cfg_en),
      .cfg_mode(cfg_mode),
      .stat_pass_count(st_pass),
      .stat_drop_count(st_drop),
      .stat_runt_count(st_runt)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Output monitor
   logic [DW-1:0] q_d[$];
   logic          q_l[$];
   logic [UW-1:0] q_u[$];
   logic [KW-1:0] q_k[$];
   int            q_oc[$];
   int            q_ic[$];
   int            cyc = 0;
   int            any_v = 0;
   int            stab_err = 0;
   int            not_idle = 0;
   logic          p_v = 1'b0;
   logic          p_r = 1'b0;
   logic [DW-1:0] p_d = '0;
   logic          p_l = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (s_if.tvalid && s_if.tready) q_ic.push_back(cyc);
         if (m_if.tvalid) any_v <= any_v + 1;
         if (m_if.tvalid && m_if.tready) begin
            q_d.push_back(m_if.tdata);
            q_l.push_back(m_if.tlast);
            q_u.push_back(m_if.tuser);
            q_k.push_back(m_if.tkeep);
            q_oc.push_back(cyc);
         end
         if (p_v && !p_r &&
             (!m_if.tvalid || m_if.tdata !== p_d || m_if.tlast !== p_l))
            stab_err <= stab_err + 1;
         if (dut.r_state != 2'd0) not_idle <= not_idle + 1;
      end
      p_v <= rst_n && m_if.tvalid;
      p_r <= m_if.tready;
      p_d <= m_if.tdata;
      p_l <= m_if.tlast;
   end

   // Transmit queue
   logic [DW-1:0] tx_d[$];
   logic [KW-1:0] tx_k[$];
   logic          tx_l[$];
   logic [UW-1:0] tx_u[$];
   int            stalls;
   int            b_any, b_stab, b_idle;

   function automatic logic [DW-1:0] mk(input int fid, input int beat,
                                        input logic [15:0] et);
      logic [DW-1:0] d;
      d = '0;
      for (int b = 0; b < KW; b++) d[8*b+:8] = 8'(fid * 16 + beat * 3 + b);
      d[96+:8]  = et[15:8];
      d[104+:8] = et[7:0];
      return d;
   endfunction

   task automatic push(input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic [UW-1:0] u);
      tx_d.push_back(d);
      tx_k.push_back(k);
      tx_l.push_back(l);
      tx_u.push_back(u);
   endtask

   task automatic clr_q();
      q_d.delete(); q_l.delete(); q_u.delete(); q_k.delete();
      q_oc.delete(); q_ic.delete();
   endtask

   task automatic mark();
      b_any  = any_v;
      b_stab = stab_err;
      b_idle = not_idle;
   endtask

   task automatic send_all();
      int to;
      stalls = 0;
      while (tx_d.size() > 0) begin
         s_if.tdata  = tx_d[0];
         s_if.tkeep  = tx_k[0];
         s_if.tlast  = tx_l[0];
         s_if.tuser  = tx_u[0];
         s_if.tvalid = 1'b1;
         to = 0;
         forever begin
            @(negedge clk);
            if (s_if.tready) break;
            stalls++;
            to++;
            if (to > 200) begin
               n_chk++; n_fail++;
               $display("FAIL send_timeout: tready stayed 0 for %0d cycles, required 1", to);
               break;
            end
         end
         @(posedge clk); #1;
         void'(tx_d.pop_front()); void'(tx_k.pop_front());
         void'(tx_l.pop_front()); void'(tx_u.pop_front());
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clr_q();
      mark();
   endtask

   task automatic test_reset();
      cfg_mode = 1'b0;
      cfg_et = {16'h0, 16'h0, 16'h0, 16'h0800};
      cfg_en = 4'b0001;
      rst_n = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata = mk(0, 0, 16'h0800);
      s_if.tkeep = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++; if (m_if.tvalid !== 1'b0) begin n_fail++;
         $display("FAIL rst_tvalid: got %b expected 0", m_if.tvalid); end
      n_chk++; if (s_if.tready !== 1'b0) begin n_fail++;
         $display("FAIL rst_tready: got %b expected 0", s_if.tready); end
      n_chk++; if (m_if.tdata !== '0) begin n_fail++;
         $display("FAIL rst_tdata: got %h expected 0", m_if.tdata); end
      n_chk++; if (st_pass !== '0 || st_drop !== '0 || st_runt !== '0) begin n_fail++;
         $display("FAIL rst_counters: got %0d/%0d/%0d expected 0/0/0",
                  st_pass, st_drop, st_runt); end
      s_if.tvalid = 1'b0;
   endtask

   task automatic test_pass();
      logic [DW-1:0] e[3];
      do_reset();
      e[0] = mk(1, 0, 16'h0800);
      e[1] = mk(1, 1, 16'h1234);
      e[2] = mk(1, 2, 16'h5678);
      push(e[0], '1, 1'b0, 1'b1);
      push(e[1], '1, 1'b0, 1'b0);
      push(e[2], 16'h00FF, 1'b1, 1'b1);
      send_all();
      drain();
      n_chk++; if (q_d.size() != 3) begin n_fail++;
         $display("FAIL pass_count_beats: got %0d expected 3", q_d.size()); end
      for (int i = 0; i < 3 && i < q_d.size(); i++) begin
         n_chk++; if (q_d[i] !== e[i]) begin n_fail++;
            $display("FAIL pass_data[%0d]: got %h expected %h", i, q_d[i], e[i]); end
         n_chk++; if (q_l[i] !== (i == 2)) begin n_fail++;
            $display("FAIL pass_last[%0d]: got %b expected %b", i, q_l[i], i == 2); end
         n_chk++; if (q_oc[i] - q_ic[i] != 1) begin n_fail++;
            $display("FAIL pass_latency[%0d]: got %0d expected 1", i, q_oc[i] - q_ic[i]); end
      end
      if (q_d.size() == 3) begin
         n_chk++; if (q_k[2] !== 16'h00FF || q_u[0] !== 1'b1 || q_u[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_keep_user: got keep %h user %b%b expected 00ff 10",
                     q_k[2], q_u[0], q_u[1]); end
      end
      n_chk++; if (st_pass !== 4'd1 || st_drop !== 4'd0) begin n_fail++;
         $display("FAIL pass_stats: got pass %0d drop %0d expected 1 0", st_pass, st_drop); end
   endtask

   task automatic test_drop();
      logic [DW-1:0] e;
      do_reset();
      for (int i = 0; i < 4; i++)
         push(mk(2, i, (i == 0) ? 16'h86DD : 16'h0800), '1, 1'(i == 3), 1'b0);
      send_all();
      drain();
      n_chk++; if (stalls != 0) begin n_fail++;
         $display("FAIL drop_tready: got %0d stall cycles expected 0", stalls); end
      n_chk++; if (any_v - b_any != 0 || q_d.size() != 0) begin n_fail++;
         $display("FAIL drop_no_output: got %0d valid cycles expected 0", any_v - b_any); end
      n_chk++; if (st_drop !== 4'd1 || st_pass !== 4'd0) begin n_fail++;
         $display("FAIL drop_stats: got drop %0d pass %0d expected 1 0", st_drop, st_pass); end
      e = mk(3, 0, 16'h0800);
      push(e, '1, 1'b1, 1'b0);
      send_all();
      drain();
      n_chk++; if (q_d.size() != 1 || q_d[0] !== e) begin n_fail++;
         $display("FAIL drop_then_pass: got %0d beats expected 1 with %h", q_d.size(), e); end
      n_chk++; if (st_pass !== 4'd1) begin n_fail++;
         $display("FAIL drop_then_pass_stat: got %0d expected 1", st_pass); end
   endtask

   task automatic test_mode1();
      logic [DW-1:0] e;
      do_reset();
      cfg_mode = 1'b1;
      cfg_et = {16'h0, 16'h0, 16'h0, 16'h0806};
      cfg_en = 4'b0001;
      e = mk(4, 0, 16'h0800);
      push(mk(4, 1, 16'h0806), '1, 1'b1, 1'b0);
      push(e, '1, 1'b1, 1'b1);
      send_all();
      drain();
      n_chk++; if (q_d.size() != 1 || q_d[0] !== e) begin n_fail++;
         $display("FAIL mode1_fwd: got %0d beats expected 1 with %h", q_d.size(), e); end
      n_chk++; if (not_idle - b_idle != 0) begin n_fail++;
         $display("FAIL mode1_idle: got %0d non-IDLE cycles expected 0", not_idle - b_idle); end
      n_chk++; if (st_drop !== 4'd1 || st_pass !== 4'd1) begin n_fail++;
         $display("FAIL mode1_stats: got drop %0d pass %0d expected 1 1", st_drop, st_pass); end
   endtask

   task automatic test_runt();
      do_reset();
      cfg_mode = 1'b0;
      cfg_et = {16'h0, 16'h0, 16'h0, 16'h0800};
      cfg_en = 4'b0001;
      push(mk(5, 0, 16'h0800), 16'h0FFF, 1'b0, 1'b0);
      push(mk(5, 1, 16'h0800), '1, 1'b1, 1'b0);
      send_all();
      drain();
      n_chk++; if (any_v - b_any != 0) begin n_fail++;
         $display("FAIL runt_no_output: got %0d valid cycles expected 0", any_v - b_any); end
      n_chk++; if (st_runt !== 4'd1 || st_drop !== 4'd1 || st_pass !== 4'd0) begin n_fail++;
         $display("FAIL runt_stats: got runt %0d drop %0d pass %0d expected 1 1 0",
                  st_runt, st_drop, st_pass); end
      // Runt overrides mode 1 pass of a non-matching frame.
      cfg_mode = 1'b1;
      cfg_et = {16'h0, 16'h0, 16'h0, 16'h0806};
      push(mk(5, 2, 16'h0800), 16'h2FFF, 1'b1, 1'b0);
      send_all();
      drain();
      n_chk++; if (q_d.size() != 0 || st_runt !== 4'd2 || st_drop !== 4'd2) begin n_fail++;
         $display("FAIL runt_mode1: got beats %0d runt %0d drop %0d expected 0 2 2",
                  q_d.size(), st_runt, st_drop); end
   endtask

   task automatic test_stall();
      logic [DW-1:0] e[4];
      logic pat[8];
      do_reset();
      cfg_mode = 1'b0;
      cfg_et = {16'h0, 16'h0, 16'h0, 16'h0800};
      cfg_en = 4'b0001;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         e[i] = mk(6, i, (i == 0) ? 16'h0800 : 16'hBEEF);
         push(e[i], '1, 1'(i == 3), 1'b0);
      end
      fork
         send_all();
         begin
            for (int i = 0; i < 8; i++) begin
               m_if.tready = pat[i];
               @(posedge clk); #1;
            end
            m_if.tready = 1'b1;
         end
      join
      drain();
      n_chk++; if (stab_err - b_stab != 0) begin n_fail++;
         $display("FAIL stall_hold: got %0d unstable cycles expected 0", stab_err - b_stab); end
      n_chk++; if (stalls == 0) begin n_fail++;
         $display("FAIL stall_backpressure: got %0d sink stalls expected >0", stalls); end
      n_chk++; if (q_d.size() != 4) begin n_fail++;
         $display("FAIL stall_beats: got %0d expected 4", q_d.size()); end
      for (int i = 0; i < 4 && i < q_d.size(); i++) begin
         n_chk++; if (q_d[i] !== e[i] || q_l[i] !== (i == 3)) begin n_fail++;
            $display("FAIL stall_data[%0d]: got %h/%b expected %h/%b",
                     i, q_d[i], q_l[i], e[i], i == 3); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e[5];
      do_reset();
      cfg_mode = 1'b0;
      cfg_et = {16'h0, 16'h88CC, 16'h86DD, 16'h0800};
      cfg_en = 4'b0101;
      e[0] = mk(7, 0, 16'h0800); e[1] = mk(7, 1, 16'h0000);
      e[2] = mk(8, 0, 16'h88CC); e[3] = mk(8, 1, 16'h0000);
      e[4] = mk(9, 0, 16'h0800);
      push(e[0], '1, 1'b0, 1'b0); push(e[1], '1, 1'b1, 1'b0);
      push(mk(10, 0, 16'h86DD), '1, 1'b1, 1'b0);
      push(e[2], '1, 1'b0, 1'b0); push(e[3], '1, 1'b1, 1'b0);
      push(mk(11, 0, 16'h0806), '1, 1'b0, 1'b0);
      push(mk(11, 1, 16'h0800), '1, 1'b0, 1'b0);
      push(mk(11, 2, 16'h0800), '1, 1'b1, 1'b0);
      push(e[4], '1, 1'b1, 1'b0);
      send_all();
      drain();
      n_chk++; if (stalls != 0) begin n_fail++;
         $display("FAIL b2b_throughput: got %0d stalls expected 0", stalls); end
      n_chk++; if (q_d.size() != 5) begin n_fail++;
         $display("FAIL b2b_beats: got %0d expected 5", q_d.size()); end
      for (int i = 0; i < 5 && i < q_d.size(); i++) begin
         n_chk++; if (q_d[i] !== e[i]) begin n_fail++;
            $display("FAIL b2b_data[%0d]: got %h expected %h", i, q_d[i], e[i]); end
      end
      n_chk++; if (st_pass !== 4'd3 || st_drop !== 4'd2) begin n_fail++;
         $display("FAIL b2b_stats: got pass %0d drop %0d expected 3 2", st_pass, st_drop); end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] e[2];
      do_reset();
      cfg_mode = 1'b0;
      cfg_et = {16'h0, 16'h0, 16'h0, 16'h0800};
      cfg_en = 4'b0001;
      push(mk(12, 0, 16'h0800), '1, 1'b0, 1'b0);
      push(mk(12, 1, 16'h0800), '1, 1'b0, 1'b0);
      send_all();
      rst_n = 1'b0;
      @(negedge clk);
      n_chk++; if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin n_fail++;
         $display("FAIL midrst_handshake: got tvalid %b tready %b expected 0 0",
                  m_if.tvalid, s_if.tready); end
      n_chk++; if (st_pass !== '0 || m_if.tdata !== '0) begin n_fail++;
         $display("FAIL midrst_clear: got pass %0d tdata %h expected 0 0",
                  st_pass, m_if.tdata); end
      @(posedge clk); #1 rst_n = 1'b1;
      clr_q();
      e[0] = mk(13, 0, 16'h0800);
      e[1] = mk(13, 1, 16'h86DD);
      push(e[0], '1, 1'b0, 1'b0);
      push(e[1], '1, 1'b1, 1'b0);
      send_all();
      drain();
      n_chk++; if (q_d.size() != 2 || q_d[0] !== e[0] || q_d[1] !== e[1] || q_l[1] !== 1'b1)
      begin n_fail++;
         $display("FAIL midrst_frame: got %0d beats expected 2 intact", q_d.size()); end
      n_chk++; if (st_pass !== 4'd1 || st_drop !== 4'd0) begin n_fail++;
         $display("FAIL midrst_stats: got pass %0d drop %0d expected 1 0", st_pass, st_drop); end
   endtask

   task automatic test_saturation();
      do_reset();
      cfg_mode = 1'b0;
      cfg_et = {16'h0, 16'h0, 16'h0, 16'h0800};
      cfg_en = 4'b0001;
      for (int i = 0; i < 17; i++) push(mk(14, i, 16'h0800), 16'h0000, 1'b1, 1'b0);
      push(mk(15, 0, 16'h0800), '1, 1'b1, 1'b0);
      send_all();
      drain();
      n_chk++; if (st_drop !== 4'hF || st_runt !== 4'hF) begin n_fail++;
         $display("FAIL sat_counters: got drop %0d runt %0d expected 15 15", st_drop, st_runt); end
      n_chk++; if (st_pass !== 4'd1 || q_d.size() != 1) begin n_fail++;
         $display("FAIL sat_pass: got pass %0d beats %0d expected 1 1", st_pass, q_d.size()); end
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = '0;
      m_if.tready = 1'b1;
      test_reset();
      test_pass();
      test_drop();
      test_mode1();
      test_runt();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
